// File: rtl/pci_cfg_pkg.sv
// pci_cfg_pkg: shared offsets, constants, command bits and MSI FSM states for the Edu PCI config space.
package pci_cfg_pkg;
  typedef enum logic [5:0] {
    OFF_ID          = 6'h00,
    OFF_CMD         = 6'h01,
    OFF_CLASS       = 6'h02,
    OFF_MISC        = 6'h03,
    OFF_BAR0        = 6'h04,
    OFF_SUBSYS      = 6'h0b,
    OFF_CAPPTR      = 6'h0d,
    OFF_INTR        = 6'h0f,
    OFF_MSI_CTL     = 6'h10,
    OFF_MSI_ADDR_LO = 6'h11,
    OFF_MSI_ADDR_HI = 6'h12,
    OFF_MSI_DATA    = 6'h13,
    OFF_MSI_MASK    = 6'h14,
    OFF_MSI_PEND    = 6'h15
  } cfg_off_e;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACKWAIT} msi_state_e;
  localparam logic [23:0] CLASS_CODE = 24'hff0000;
  localparam logic [7:0] CAP_ID_MSI = 8'h05;
  localparam logic [7:0] CAP_PTR = 8'h40;
  localparam logic [7:0] INT_PIN = 8'h01;
  localparam int CMD_IO = 0;
  localparam int CMD_MEM = 1;
  localparam int CMD_BM = 2;
  localparam int CMD_MWI = 4;
  localparam int CMD_PERR = 6;
  localparam int CMD_SERR = 8;
  localparam int CMD_FBB = 9;
  localparam int CMD_INTD = 10;
  localparam logic [15:0] CMD_WMASK = 16'((1 << CMD_IO) | (1 << CMD_MEM) | (1 << CMD_BM) | (1 << CMD_MWI) |
                                          (1 << CMD_PERR) | (1 << CMD_SERR) | (1 << CMD_FBB) | (1 << CMD_INTD));
  function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] val, input logic [3:0] be);
    for (int i = 0; i < 4; i++) be_merge[8*i +: 8] = be[i] ? val[8*i +: 8] : old[8*i +: 8];
  endfunction
endpackage

// File: rtl/pci_msi_arb.sv
// pci_msi_arb: pending interrupt vector, lowest-index priority grant and MSI issue FSM, plus INTx level.
module pci_msi_arb
  import pci_cfg_pkg::*;
#(
  parameter int NUM_VECTORS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_VECTORS-1:0] intr_req,
  input  logic [NUM_VECTORS-1:0] intr_clr,
  input  logic                   msi_enable,
  input  logic                   bus_master,
  input  logic                   intr_disable,
  input  logic [NUM_VECTORS-1:0] mask,
  input  logic [2:0]             mme,
  input  logic [61:0]            addr,
  input  logic [15:0]            data,
  input  logic                   msi_ack,
  output logic [NUM_VECTORS-1:0] pending,
  output logic                   msi_req,
  output logic [63:0]            msi_addr,
  output logic [31:0]            msi_data,
  output logic                   intx_assert
);
  msi_state_e state, state_n;
  logic [4:0] vec, vec_n;
  logic [NUM_VECTORS-1:0] elig, clr, pending_n;
  logic [15:0] mme_mask;
  assign elig = pending & ~mask;
  assign mme_mask = ~(16'hffff << mme);
  always_comb begin
    vec_n = '0;
    for (int i = NUM_VECTORS - 1; i >= 0; i--) if (elig[i]) vec_n = 5'(i);
  end
  // set wins over any clear landing on the same bit in the same cycle
  assign clr = (msi_enable ? '0 : intr_clr) | (state == ST_ACKWAIT ? NUM_VECTORS'(1) << vec : '0);
  assign pending_n = (pending & ~clr) | intr_req;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state == ST_IDLE ? (msi_enable && bus_master && |elig ? ST_REQ : ST_IDLE) :
              state == ST_REQ  ? (msi_ack ? ST_ACKWAIT : ST_REQ) : ST_IDLE;
  end
  always_comb begin
    msi_req = state == ST_REQ;
  end
  // address/data are captured at grant so software rewrites cannot disturb an outstanding request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      vec <= '0;
      msi_addr <= '0;
      msi_data <= '0;
      intx_assert <= 1'b0;
    end else begin
      pending <= pending_n;
      intx_assert <= !msi_enable && !intr_disable && |pending_n;
      if (state == ST_IDLE && state_n == ST_REQ) begin
        vec <= vec_n;
        msi_addr <= {addr, 2'b00};
        msi_data <= {16'h0, (data & ~mme_mask) | (16'(vec_n) & mme_mask)};
      end
    end
  end
endmodule

// File: rtl/pci_cfg_msi_mv.sv
// pci_cfg_msi_mv: Edu type-0 config space with sized BAR0 and multi-vector MSI.
// Define PCI_CFG_MSI_PVM_EN to add MSI per-vector masking (mask at 0x14, pending at 0x15).
module pci_cfg_msi_mv
  import pci_cfg_pkg::*;
#(
  parameter logic [15:0] VENDOR_ID = 16'h1234,
  parameter logic [15:0] DEVICE_ID = 16'h11e8,
  parameter logic [7:0]  REVISION = 8'h0a,
  parameter int          BAR0_SIZE_LOG2 = 12,
  parameter int          NUM_VECTORS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_enable,
  input  logic                        cfg_iswrite,
  input  logic [5:0]                  cfg_offset,
  input  logic [3:0]                  cfg_byte_en,
  input  logic [31:0]                 cfg_write_val,
  output logic [31:0]                 cfg_read_val,
  output logic                        cfg_read_valid,
  input  logic [5:0]                  status_err,
  input  logic [NUM_VECTORS-1:0]      intr_req,
  input  logic [NUM_VECTORS-1:0]      intr_clr,
  output logic [31-BAR0_SIZE_LOG2:0]  bar0_base,
  output logic                        mem_en,
  output logic                        bus_master,
  output logic                        msi_req,
  output logic [63:0]                 msi_addr,
  output logic [31:0]                 msi_data,
  input  logic                        msi_ack,
  output logic                        intx_assert
);
  localparam logic [2:0] MMC = 3'($clog2(NUM_VECTORS));
`ifdef PCI_CFG_MSI_PVM_EN
  localparam logic PVM_CAP = 1'b1;
`else
  localparam logic PVM_CAP = 1'b0;
`endif
  logic [15:0] cmd, status, data;
  logic [7:0] cls, int_line;
  logic [4:0] lat;
  logic [31-BAR0_SIZE_LOG2:0] bar;
  logic [31:0] ssid, addr_hi, rdata, wdata;
  logic [29:0] addr_lo;
  logic msi_en, we, re;
  logic [2:0] mme;
  logic [NUM_VECTORS-1:0] mask, pending;
  assign we = cfg_enable && cfg_iswrite;
  assign re = cfg_enable && !cfg_iswrite;
  assign status = {status_err[5:1], 2'b00, status_err[0], 3'b000, 1'b1, |pending, 3'b000};
  assign bar0_base = bar;
  assign mem_en = cmd[CMD_MEM];
  assign bus_master = cmd[CMD_BM];
  always_comb begin
    rdata = '0;
    case (cfg_offset)
      OFF_ID:          rdata = {DEVICE_ID, VENDOR_ID};
      OFF_CMD:         rdata = {status, cmd};
      OFF_CLASS:       rdata = {CLASS_CODE, REVISION};
      OFF_MISC:        rdata = {16'h0, lat, 3'b000, cls};
      OFF_BAR0:        rdata = {bar, {BAR0_SIZE_LOG2{1'b0}}};
      OFF_SUBSYS:      rdata = ssid;
      OFF_CAPPTR:      rdata = {24'h0, CAP_PTR};
      OFF_INTR:        rdata = {16'h0, INT_PIN, int_line};
      OFF_MSI_CTL:     rdata = {7'h0, PVM_CAP, 1'b1, mme, MMC, msi_en, 8'h00, CAP_ID_MSI};
      OFF_MSI_ADDR_LO: rdata = {addr_lo, 2'b00};
      OFF_MSI_ADDR_HI: rdata = addr_hi;
      OFF_MSI_DATA:    rdata = {16'h0, data};
`ifdef PCI_CFG_MSI_PVM_EN
      OFF_MSI_MASK:    rdata = 32'(mask);
      OFF_MSI_PEND:    rdata = 32'(pending);
`endif
      default:         rdata = '0;
    endcase
  end
  // merging against the current readback keeps unwritten lanes and read-only bits intact
  assign wdata = be_merge(rdata, cfg_write_val, cfg_byte_en);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd <= '0;
      cls <= '0;
      lat <= '0;
      bar <= '0;
      ssid <= {DEVICE_ID, VENDOR_ID};
      int_line <= '0;
      msi_en <= 1'b0;
      mme <= '0;
      addr_lo <= '0;
      addr_hi <= '0;
      data <= '0;
    end else if (we) begin
      case (cfg_offset)
        OFF_CMD:         cmd <= wdata[15:0] & CMD_WMASK;
        OFF_MISC:        {lat, cls} <= {wdata[15:11], wdata[7:0]};
        OFF_BAR0:        bar <= wdata[31:BAR0_SIZE_LOG2];
        OFF_SUBSYS:      ssid <= wdata;
        OFF_INTR:        int_line <= wdata[7:0];
        OFF_MSI_CTL:     {mme, msi_en} <= {wdata[22:20] > MMC ? MMC : wdata[22:20], wdata[16]};
        OFF_MSI_ADDR_LO: addr_lo <= wdata[31:2];
        OFF_MSI_ADDR_HI: addr_hi <= wdata;
        OFF_MSI_DATA:    data <= wdata[15:0];
        default: ;
      endcase
    end
  end
`ifdef PCI_CFG_MSI_PVM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mask <= '0;
    else if (we && cfg_offset == OFF_MSI_MASK) mask <= wdata[NUM_VECTORS-1:0];
  end
`else
  assign mask = '0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_read_val <= '0;
      cfg_read_valid <= 1'b0;
    end else begin
      cfg_read_valid <= re;
      if (re) cfg_read_val <= rdata;
    end
  end
  pci_msi_arb #(.NUM_VECTORS(NUM_VECTORS)) u_arb (
    .clk(clk),
    .rst(rst),
    .intr_req(intr_req),
    .intr_clr(intr_clr),
    .msi_enable(msi_en),
    .bus_master(cmd[CMD_BM]),
    .intr_disable(cmd[CMD_INTD]),
    .mask(mask),
    .mme(mme),
    .addr({addr_hi, addr_lo}),
    .data(data),
    .msi_ack(msi_ack),
    .pending(pending),
    .msi_req(msi_req),
    .msi_addr(msi_addr),
    .msi_data(msi_data),
    .intx_assert(intx_assert)
  );
endmodule

// File: doc/pci_cfg_msi_mv.md
Name: pci_cfg_msi_mv

Overview:
- Next-generation PCI type-0 configuration space for the Edu device, with parametrised BAR0 size and multi-vector MSI.
- Adds byte-enable writes, BAR sizing, a registered read-valid handshake, and an MSI issue state machine that drives the bus-master write engine.
- Sits between the PCI target configuration decoder and the device core and master engine.
- Also produces INTx when MSI is disabled.

Parameters:
- VENDOR_ID, 16'h1234, vendor ID (read-only).
- DEVICE_ID, 16'h11e8, device ID (read-only).
- REVISION, 8'h0a, revision ID.
- BAR0_SIZE_LOG2, 12, BAR0 memory window size; legal range 4..31.
- NUM_VECTORS, 4, interrupt sources; power of two, 1..32.

Ports:
- clk  in  1  configuration clock.
- rst  in  1  asynchronous active-low reset.
- cfg_enable  in  1  access strobe, one cycle per access.
- cfg_iswrite  in  1  1 = write, 0 = read.
- cfg_offset  in  6  dword index.
- cfg_byte_en  in  4  write byte lanes.
- cfg_write_val  in  32  write data.
- cfg_read_val  out  32  read data.
- cfg_read_valid  out  1  read data valid pulse.
- status_err  in  6  {detected_parity, signaled_serr, rcvd_master_abort, rcvd_target_abort, signaled_target_abort, master_data_parity}.
- intr_req  in  NUM_VECTORS  one-cycle event pulses.
- intr_clr  in  NUM_VECTORS  INTx pending clear pulses.
- bar0_base  out  32-BAR0_SIZE_LOG2  decoded BAR0 base.
- mem_en  out  1  command memory space enable.
- bus_master  out  1  command bus master enable.
- msi_req  out  1  MSI write request.
- msi_addr  out  64  MSI address.
- msi_data  out  32  MSI data.
- msi_ack  in  1  master engine accepted the request.
- intx_assert  out  1  INTA# level.

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs 0.
  - Command register, BAR0, MSI registers and pending vector all 0.
  - Interrupt line 0.
  - Subsystem ID/vendor ID default to DEVICE_ID/VENDOR_ID.
  - FSM in IDLE.
- Reads:
  - Read strobe in cycle N -> cfg_read_val valid with cfg_read_valid=1 in cycle N+1.
  - cfg_read_valid is a single-cycle pulse; cfg_read_val holds its value until the next read.
  - Unimplemented offsets read 0.
- Writes:
  - Only lanes with cfg_byte_en set are updated.
  - Read-only fields and read-only offsets ignore writes.
  - No read-valid pulse on a write.
- Register map:
  - 0x00 ID.
  - 0x01 command/status:
    - Status bit 4 = 1 (capabilities list).
    - Status bit 3 = |pending.
    - Status error bits are live inputs.
    - Writable command bits: 0, 1, 2, 4, 6, 8, 9, 10.
  - 0x02 class FF0000, rev = REVISION.
  - 0x03 cacheline size RW, latency timer [15:11] RW, header type 0.
  - 0x04 BAR0:
    - Bits [31:BAR0_SIZE_LOG2] RW; lower bits read 0 (32-bit, non-prefetchable memory).
    - Writing all-ones reads back the size mask.
  - 0x05-0x0a and 0x0c read 0.
  - 0x0b subsystem IDs, writable.
  - 0x0d capability pointer 0x40.
  - 0x0f interrupt line RW, interrupt pin 01.
  - 0x10 MSI control/ID 05:
    - Multiple Message Capable = log2(NUM_VECTORS).
    - MME [22:20] RW, clamped to MMC on write.
    - Enable bit 16 RW.
    - 64-bit capable.
  - 0x11 address lower [31:2].
  - 0x12 address upper.
  - 0x13 data [15:0].
- Pending vector:
  - Set by intr_req.
  - Cleared by intr_clr in INTx mode, or by msi_ack for the granted vector.
  - Set and clear of the same bit in the same cycle: set wins.
- MSI FSM:
  - IDLE: if msi_enable && bus_master && |pending, latch the lowest pending index v and go to REQ.
  - REQ:
    - msi_req=1; msi_addr = {addr,2'b00}.
    - msi_data = {16'h0, data with low MME bits replaced by v & (2^MME-1)}.
    - Both stay stable until msi_ack; on msi_ack go to ACKWAIT.
  - ACKWAIT: clear pending[v], return to IDLE. This gives a minimum of 1 idle cycle between requests.
  - Clearing msi_enable or bus_master while in REQ does not abort; the request holds until msi_ack.
- INTx: intx_assert = !msi_enable && !intr_disable && |pending, registered.

Optional Feature:
- Macro: PCI_CFG_MSI_PVM_EN.
- Defined:
  - Per-vector masking capable bit = 1; capability grows to 0x14 mask and 0x15 pending (read-only).
  - Masked vectors stay pending but are not granted; unmasking a pending vector triggers issue.
  - 64-bit and per-vector masking are both set.
- Undefined: capable bit 0; 0x14 and 0x15 read 0; no masking.

Decomposition:
- Package pci_cfg_pkg holds:
  - Register offset enum.
  - Class, capability ID and pointer constants.
  - Command bit index constants.
  - MSI FSM state enum.
- Sub-module pci_msi_arb holds the pending register, priority encoder and MSI FSM. The parent keeps the register file and read mux.

Test Plan:
- Reset, then read 0x00 -> cycle N+1 cfg_read_val=32'h11e81234, cfg_read_valid=1 for one cycle.
- Write 0xFFFFFFFF to 0x04, then read -> 32'hFFFFF000 (BAR0_SIZE_LOG2=12); write 0x12345678 -> bar0_base=20'h12345.
- Write 0x13 with byte_en=4'b0001 value 0xABCD -> MSI data reads 0x00CD.
- MSI enable, MME=2, bus_master=1, data=0x40, intr_req=4'b1010 -> msi_data=0x41 first, ack, then 0x43; pending then 0.
- MSI disabled, intr_req[2] -> intx_assert=1 next cycle and status bit 3=1; intr_clr[2] -> deasserts; intr_disable=1 masks assertion.
- Drop msi_enable while in REQ -> msi_req holds until msi_ack. Assert rst mid-REQ -> msi_req=0 immediately and pending cleared.
